// File: rtl/leb128_u32_stream_dec.sv
// Serial unsigned 32-bit LEB128 decoder: one encoded byte in per handshake,
// one decoded value plus a malformed flag out per complete encoding.
// Optional macro LEB128_LEN_EN adds o_len, the byte count of each encoding.
module leb128_u32_stream_dec #(
    parameter int unsigned MAX_BYTES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [31:0] o_data,
    output logic        o_err,
    output logic        o_valid,
    input  logic        o_ready
`ifdef LEB128_LEN_EN
    ,
    output logic [2:0]  o_len
`endif
);

    localparam int unsigned GRP_W = 7;
    localparam logic [2:0]  LAST  = 3'(MAX_BYTES - 1);

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [31:0] acc;
    logic [4:0]  shamt;
    logic [31:0] grp;
    logic        accept;

    // Ready depends on state alone so upstream never sees a combinational loop.
    assign i_ready = (state != HOLD);
    assign accept  = i_valid && i_ready;
    assign o_data  = acc;

    // Payload group placed at its 7-bit slot; the 5th group naturally truncates to 4 bits.
    assign shamt = 5'(GRP_W * 32'(cnt));
    assign grp   = 32'(i_data[6:0]) << shamt;

    // Decode FSM: accumulate groups, discard overlong tail, hold result until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ACC;
            cnt     <= 3'd0;
            acc     <= 32'd0;
            o_err   <= 1'b0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (accept) begin
                        acc <= acc | grp;
                        if (cnt == LAST) begin
                            if (i_data[7]) begin
                                state <= DRAIN;
                                o_err <= 1'b1;
                            end else begin
                                state   <= HOLD;
                                o_valid <= 1'b1;
                                o_err   <= |i_data[6:4];
                            end
                        end else if (i_data[7]) begin
                            cnt <= cnt + 3'd1;
                        end else begin
                            state   <= HOLD;
                            o_valid <= 1'b1;
                            o_err   <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (accept && !i_data[7]) begin
                        state   <= HOLD;
                        o_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (o_ready) begin
                        state   <= ACC;
                        o_valid <= 1'b0;
                        o_err   <= 1'b0;
                        acc     <= 32'd0;
                        cnt     <= 3'd0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

`ifdef LEB128_LEN_EN
    // Byte count of the current encoding, saturating at 7 for long overlong tails.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_len <= 3'd0;
        end else if (state == HOLD) begin
            if (o_ready) begin
                o_len <= 3'd0;
            end
        end else if (accept && (o_len != 3'd7)) begin
            o_len <= o_len + 3'd1;
        end
    end
`endif

endmodule

// File: tb/tb_leb128_u32_stream_dec.sv
// Self-checking bench for leb128_u32_stream_dec: directed table, corner
// sequences (backpressure, async reset) and random encodings vs a reference decoder.
module tb_leb128_u32_stream_dec;

    typedef logic [7:0] bq_t [$];

    typedef struct {
        logic [63:0] enc;
        int          n;
        logic [31:0] d;
        logic        e;
        int          l;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          l;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid;
    logic        i_ready;
    logic [31:0] o_data;
    logic        o_err;
    logic        o_valid;
    logic        o_ready;
`ifdef LEB128_LEN_EN
    logic [2:0]  o_len;
`endif

    int errors = 0;
    int checks = 0;
    bit bubbles = 1'b0;

    leb128_u32_stream_dec dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_err   (o_err),
        .o_valid (o_valid),
        .o_ready (o_ready)
`ifdef LEB128_LEN_EN
        ,
        .o_len   (o_len)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decoder: sum of 7-bit groups of the first five bytes, truncated to 32 bits.
    function automatic res_t ref_decode(input bq_t q);
        res_t r;
        longint unsigned v = 0;
        for (int i = 0; i < q.size() && i < 5; i++)
            v = v + (longint'(q[i] & 8'h7f) << (7 * i));
        r.d = v[31:0];
        r.e = (q.size() > 5) || ((q.size() == 5) && ((q[4] & 8'h70) != 8'h00));
        r.l = (q.size() > 7) ? 7 : q.size();
        return r;
    endfunction

    // Presents one byte and returns right after the edge that accepts it.
    task automatic push_byte(input logic [7:0] b);
        int waited = 0;
        if (bubbles && ($urandom_range(3) == 0)) begin
            @(negedge clk);
            i_valid = 1'b0;
            i_data  = 8'($urandom);
        end
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = b;
        while (!i_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!i_ready) chk("push_timeout", 32'(i_ready), 32'd1);
        @(posedge clk);
    endtask

    task automatic push_seq(input bq_t q);
        foreach (q[i]) push_byte(q[i]);
    endtask

    // Checks the result one cycle after the final byte, holds it for 'hold' cycles, then takes it.
    task automatic expect_result(input string tag, input logic [31:0] d, input logic e,
                                 input int l, input int hold);
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = 8'($urandom);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'd1);
        chk({tag, ".i_ready_hold"}, 32'(i_ready), 32'd0);
        chk({tag, ".o_data"}, o_data, d);
        chk({tag, ".o_err"}, 32'(o_err), 32'(e));
`ifdef LEB128_LEN_EN
        chk({tag, ".o_len"}, 32'(o_len), 32'(l));
`endif
        for (int k = 0; k < hold; k++) begin
            o_ready = 1'b0;
            @(negedge clk);
            chk({tag, ".bp_valid"}, 32'(o_valid), 32'd1);
            chk({tag, ".bp_data"}, o_data, d);
            chk({tag, ".bp_ready"}, 32'(i_ready), 32'd0);
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk({tag, ".taken_valid"}, 32'(o_valid), 32'd0);
        chk({tag, ".taken_ready"}, 32'(i_ready), 32'd1);
    endtask

    vec_t tbl [7];

    initial begin
        bq_t  q;
        res_t r;

        tbl[0] = '{64'h0000_0000_0026_8ee5, 3, 32'h0009_8765, 1'b0, 3};
        tbl[1] = '{64'h0000_0000_0000_0000, 1, 32'd0,         1'b0, 1};
        tbl[2] = '{64'h0000_0000_0000_007f, 1, 32'd127,       1'b0, 1};
        tbl[3] = '{64'h0000_000f_ffff_ffff, 5, 32'hffff_ffff, 1'b0, 5};
        tbl[4] = '{64'h0000_001f_ffff_ffff, 5, 32'hffff_ffff, 1'b1, 5};
        tbl[5] = '{64'h0000_8080_8080_8080, 7, 32'd0,         1'b1, 7};
        tbl[6] = '{64'h0000_0000_0000_0005, 1, 32'd5,         1'b0, 1};

        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = 8'h00;
        o_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst.o_valid", 32'(o_valid), 32'd0);
        chk("rst.o_err", 32'(o_err), 32'd0);
        chk("rst.o_data", o_data, 32'd0);
        chk("rst.i_ready", 32'(i_ready), 32'd1);
`ifdef LEB128_LEN_EN
        chk("rst.o_len", 32'(o_len), 32'd0);
`endif
        rst = 1'b0;

        // Directed table.
        foreach (tbl[t]) begin
            logic [63:0] enc;
            enc = tbl[t].enc;
            q = {};
            for (int i = 0; i < tbl[t].n; i++) q.push_back(enc[8*i +: 8]);
            push_seq(q);
            expect_result($sformatf("vec%0d", t), tbl[t].d, tbl[t].e, tbl[t].l, 0);
        end

        // Backpressure on a single-byte encoding.
        q = '{8'h2a};
        push_seq(q);
        expect_result("backpressure", 32'd42, 1'b0, 1, 4);

        // Async reset mid-encoding discards the partial value.
        q = '{8'he5, 8'h8e};
        push_seq(q);
        #2 rst = 1'b1;
        #1;
        chk("arst_mid.o_valid", 32'(o_valid), 32'd0);
        chk("arst_mid.i_ready", 32'(i_ready), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = 1'b0;
        q = '{8'h01};
        push_seq(q);
        expect_result("after_arst", 32'd1, 1'b0, 1, 0);

        // Async reset while a result is held drops it immediately.
        q = '{8'h2a};
        push_seq(q);
        @(negedge clk);
        i_valid = 1'b0;
        o_ready = 1'b0;
        chk("arst_hold.pre_valid", 32'(o_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_hold.o_valid", 32'(o_valid), 32'd0);
        chk("arst_hold.i_ready", 32'(i_ready), 32'd1);
        @(negedge clk);
        rst     = 1'b0;
        o_ready = 1'b1;

        // Random encodings of 1..9 bytes with input bubbles and output stalls.
        bubbles = 1'b1;
        for (int t = 0; t < 150; t++) begin
            int n;
            n = $urandom_range(9, 1);
            q = {};
            for (int i = 0; i < n - 1; i++) q.push_back(8'h80 | 8'($urandom_range(127)));
            if (n == 5 && $urandom_range(1) == 0)
                q.push_back(8'($urandom_range(15)));
            else
                q.push_back(8'($urandom_range(127)));
            r = ref_decode(q);
            push_seq(q);
            expect_result($sformatf("rnd%0d", t), r.d, r.e, r.l, $urandom_range(2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
